// File: rtl/bus2_pkg.sv
// Shared definitions for the bus2 cache-to-memory-controller line bus.
package bus2_pkg;

    localparam int ADDR2_BUS_SIZE    = 14;
    localparam int DATA_BUS_SIZE     = 16;
    localparam int CTR2_BUS_SIZE     = 2;
    localparam int CACHE_LINE_SIZE   = 16;
    localparam int CACHE_OFFSET_SIZE = 4;
    localparam int BEATS             = CACHE_LINE_SIZE / 2;
    localparam int LINE_BITS         = CACHE_LINE_SIZE * 8;
    localparam int RESP_TIMEOUT      = 255;
    localparam int BEAT_CNT_W        = $clog2(BEATS);
    localparam int RESP_CNT_W        = $clog2(RESP_TIMEOUT + 1);

    typedef enum logic [CTR2_BUS_SIZE-1:0] {
        C2_NOP        = 2'd0,
        C2_RESPONSE   = 2'd1,
        C2_READ_LINE  = 2'd2,
        C2_WRITE_LINE = 2'd3
    } c2_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_BEAT,
        ST_RD_CMD,
        ST_WAIT_RESP,
        ST_RD_BEAT
    } master_state_t;

endpackage

// File: rtl/bus2_beat_shifter.sv
// Line-wide shift register for bus2 beats: loads a whole line and shifts it
// out 16 bits at a time, or assembles a line from 16-bit beats shifted in at
// the top so that the first beat ends up in the lowest bytes.
module bus2_beat_shifter
    import bus2_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [LINE_BITS-1:0]     load_data,
    input  logic                     shift_out,
    input  logic                     shift_in,
    input  logic [DATA_BUS_SIZE-1:0] beat_in,
    output logic [DATA_BUS_SIZE-1:0] beat_out,
    output logic [LINE_BITS-1:0]     line_after_shift_in,
    output logic                     last_beat
);

    logic [LINE_BITS-1:0]  line_q, line_d;
    logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;

    assign beat_out            = line_q[DATA_BUS_SIZE-1:0];
    assign line_after_shift_in = {beat_in, line_q[LINE_BITS-1:DATA_BUS_SIZE]};
    assign last_beat           = (cnt_q == BEAT_CNT_W'(BEATS - 1));

    // Next line contents and beat count; the count saturates at the last beat.
    always_comb begin
        line_d = line_q;
        cnt_d  = cnt_q;
        if (load) begin
            line_d = load_data;
            cnt_d  = '0;
        end else if (shift_out || shift_in) begin
            line_d = shift_out ? (line_q >> DATA_BUS_SIZE) : line_after_shift_in;
            if (!last_beat) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Line and beat-count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
            cnt_q  <= '0;
        end else begin
            line_q <= line_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/bus2_line_master.sv
// Cache-side bus2 initiator: issues one line read or write at a time, moves
// the line 16 bits per cycle and waits (with a timeout) for the controller's
// response. All bus outputs come straight from registers.
module bus2_line_master
    import bus2_pkg::*;
(
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      req_valid,
    input  logic                      req_write,
    input  logic [ADDR2_BUS_SIZE-1:0] req_addr,
    input  logic [LINE_BITS-1:0]      req_wdata,
    output logic                      req_ready,
    output logic                      rsp_done,
    output logic                      rsp_err,
    output logic [LINE_BITS-1:0]      rsp_rdata,
    output logic [ADDR2_BUS_SIZE-1:0] A2_OUT,
    output logic                      A2_OE,
    output logic [DATA_BUS_SIZE-1:0]  D2_OUT,
    input  logic [DATA_BUS_SIZE-1:0]  D2_IN,
    output logic                      D2_OE,
    output logic [CTR2_BUS_SIZE-1:0]  C2_OUT,
    input  logic [CTR2_BUS_SIZE-1:0]  C2_IN,
    output logic                      C2_OE
);

    master_state_t             state_q, state_d;
    logic                      write_q, write_d;
    logic [ADDR2_BUS_SIZE-1:0] addr_q, addr_d;
    logic [RESP_CNT_W-1:0]     resp_cnt_q, resp_cnt_d;
    logic                      a2_oe_q, a2_oe_d;
    logic                      c2_oe_q, c2_oe_d;
    logic                      d2_oe_q, d2_oe_d;
    logic [ADDR2_BUS_SIZE-1:0] a2_out_q, a2_out_d;
    logic [CTR2_BUS_SIZE-1:0]  c2_out_q, c2_out_d;
    logic                      req_ready_q, req_ready_d;
    logic                      rsp_done_q, rsp_done_d;
    logic                      rsp_err_q, rsp_err_d;
    logic [LINE_BITS-1:0]      rsp_rdata_q, rsp_rdata_d;

    logic                      sh_load;
    logic [LINE_BITS-1:0]      sh_load_data;
    logic                      sh_shift_out;
    logic                      sh_shift_in;
    logic [DATA_BUS_SIZE-1:0]  sh_beat_out;
    logic [LINE_BITS-1:0]      sh_line_in;
    logic                      sh_last;

    bus2_beat_shifter u_shifter (
        .clk                 (CLK),
        .rst_n               (RESET),
        .load                (sh_load),
        .load_data           (sh_load_data),
        .shift_out           (sh_shift_out),
        .shift_in            (sh_shift_in),
        .beat_in             (D2_IN),
        .beat_out            (sh_beat_out),
        .line_after_shift_in (sh_line_in),
        .last_beat           (sh_last)
    );

    assign req_ready = req_ready_q;
    assign rsp_done  = rsp_done_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign A2_OUT    = a2_out_q;
    assign A2_OE     = a2_oe_q;
    assign C2_OUT    = c2_out_q;
    assign C2_OE     = c2_oe_q;
    assign D2_OE     = d2_oe_q;
    assign D2_OUT    = d2_oe_q ? sh_beat_out : '0;

    // Next-state and next-output logic; bus enables default to released so
    // every exit from a driving state gives the mandatory turnaround cycle.
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        addr_d       = addr_q;
        resp_cnt_d   = resp_cnt_q;
        a2_oe_d      = 1'b0;
        c2_oe_d      = 1'b0;
        d2_oe_d      = 1'b0;
        a2_out_d     = '0;
        c2_out_d     = C2_NOP;
        rsp_done_d   = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        sh_load      = 1'b0;
        sh_load_data = '0;
        sh_shift_out = 1'b0;
        sh_shift_in  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d       = req_addr;
                    write_d      = req_write;
                    sh_load      = 1'b1;
                    sh_load_data = req_write ? req_wdata : '0;
                    a2_oe_d      = 1'b1;
                    c2_oe_d      = 1'b1;
                    a2_out_d     = req_addr;
                    if (req_write) begin
                        state_d  = ST_WR_BEAT;
                        d2_oe_d  = 1'b1;
                        c2_out_d = C2_WRITE_LINE;
                    end else begin
                        state_d  = ST_RD_CMD;
                        c2_out_d = C2_READ_LINE;
                    end
                end
            end
            ST_WR_BEAT: begin
                sh_shift_out = 1'b1;
                if (sh_last) begin
                    state_d    = ST_WAIT_RESP;
                    resp_cnt_d = '0;
                end else begin
                    a2_oe_d  = 1'b1;
                    c2_oe_d  = 1'b1;
                    d2_oe_d  = 1'b1;
                    a2_out_d = addr_q;
                    c2_out_d = C2_WRITE_LINE;
                end
            end
            ST_RD_CMD: begin
                state_d    = ST_WAIT_RESP;
                resp_cnt_d = '0;
            end
            ST_WAIT_RESP: begin
                if (C2_IN == C2_RESPONSE) begin
                    if (write_q) begin
                        rsp_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        sh_shift_in = 1'b1;
                        state_d     = ST_RD_BEAT;
                    end
                end else if (resp_cnt_q == RESP_CNT_W'(RESP_TIMEOUT - 1)) begin
                    rsp_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    resp_cnt_d = resp_cnt_q + 1'b1;
                end
            end
            ST_RD_BEAT: begin
                sh_shift_in = 1'b1;
                if (sh_last) begin
                    rsp_rdata_d = sh_line_in;
                    rsp_done_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_ready_d = (state_d == ST_IDLE) && !rsp_done_d;
    end

    // Controller state and registered outputs; reset releases the bus at once.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            resp_cnt_q  <= '0;
            a2_oe_q     <= 1'b0;
            c2_oe_q     <= 1'b0;
            d2_oe_q     <= 1'b0;
            a2_out_q    <= '0;
            c2_out_q    <= '0;
            req_ready_q <= 1'b1;
            rsp_done_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            resp_cnt_q  <= resp_cnt_d;
            a2_oe_q     <= a2_oe_d;
            c2_oe_q     <= c2_oe_d;
            d2_oe_q     <= d2_oe_d;
            a2_out_q    <= a2_out_d;
            c2_out_q    <= c2_out_d;
            req_ready_q <= req_ready_d;
            rsp_done_q  <= rsp_done_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule
